fibonacci_datapath: RTL and testbench

- Datapath partner of the Fibonacci control unit.
- Consumes the control unit's enable and select strobes (En_reg1, En_reg2, En_Count, En_N, Select), iterates F(k), and returns Stop to the control unit when the iteration count reaches the loaded N.
- Exposes the result F(N), a wrap-around flag and a one-cycle completion pulse to the surrounding design.

---
 rtl/fibonacci_datapath.sv | 123 ++++++++++++
 tb/tb_fibonacci_datapath.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_datapath.sv
// -----------------------------------------------------------------------------
// fibonacci_datapath
//   Datapath half of the Fibonacci engine. The control unit drives the enable
//   and select strobes. This block iterates the pair (reg1, reg2) = (F(k), F(k+1)).
//   It reports Stop back to the controller once the iteration count equals the
//   loaded N.
//
// Ports
//   clock      system clock; all state updates on the rising edge
//   reset      synchronous active-low reset
//   N_in       requested index N, captured when En_N=1
//   En_reg1    reg1 <= reg2
//   En_reg2    reg2 <= reg1 + reg2 (mod 2^WIDTH)
//   En_Count   count <= count + 1
//   En_N       n_reg <= N_in
//   Select     1 = initialise datapath, 0 = iterate
//   Stop       combinational, count == n_reg
//   fib_out    reg1, i.e. F(count)
//   count_out  current iteration count
//   overflow   sticky flag, fib_out has wrapped modulo 2^WIDTH
//   done       one-cycle pulse, one cycle after Stop rises in a run
// -----------------------------------------------------------------------------
module fibonacci_datapath #(
    parameter int WIDTH   = 16,
    parameter int N_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_WIDTH-1:0] N_in,
    input  logic               En_reg1,
    input  logic               En_reg2,
    input  logic               En_Count,
    input  logic               En_N,
    input  logic               Select,
    output logic               Stop,
    output logic [WIDTH-1:0]   fib_out,
    output logic [N_WIDTH-1:0] count_out,
    output logic               overflow,
    output logic               done
);

    logic [WIDTH-1:0]   reg1_q, reg1_d;
    logic [WIDTH-1:0]   reg2_q, reg2_d;
    logic [N_WIDTH-1:0] count_q, count_d;
    logic [N_WIDTH-1:0] n_q, n_d;
    logic               ovf1_q, ovf1_d;
    logic               ovf2_q, ovf2_d;
    logic               stop_d_q, stop_d_d;
    logic               done_q, done_d;

    // Carry out of the add marks the first time reg2 wraps.
    logic [WIDTH:0]     sum;

    assign sum  = {1'b0, reg1_q} + {1'b0, reg2_q};
    assign Stop = (count_q == n_q);

    always_comb begin
        reg1_d   = reg1_q;
        reg2_d   = reg2_q;
        count_d  = count_q;
        n_d      = n_q;
        ovf1_d   = ovf1_q;
        ovf2_d   = ovf2_q;

        if (En_N)
            n_d = N_in;

        if (Select) begin
            reg1_d  = '0;
            reg2_d  = {{(WIDTH-1){1'b0}}, 1'b1};
            count_d = '0;
            ovf1_d  = 1'b0;
            ovf2_d  = 1'b0;
        end else if (!Stop) begin
            // While Stop is high, the state holds. This absorbs the cycle the
            // controller needs to leave its iterate state, so count never
            // overshoots n_reg.
            if (En_reg1) begin
                reg1_d = reg2_q;
                ovf1_d = ovf2_q;
            end
            if (En_reg2) begin
                reg2_d = sum[WIDTH-1:0];
                ovf2_d = ovf2_q | sum[WIDTH] | ovf1_q;
            end
            if (En_Count)
                count_d = count_q + 1'b1;
        end

        // Select forces stop_d high, so the init cycle itself is never seen
        // as a rising edge of Stop.
        stop_d_d = Select ? 1'b1 : Stop;
        done_d   = Stop & ~stop_d_q & ~Select;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            reg1_q   <= '0;
            reg2_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
            count_q  <= '0;
            n_q      <= '0;
            ovf1_q   <= 1'b0;
            ovf2_q   <= 1'b0;
            stop_d_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            reg1_q   <= reg1_d;
            reg2_q   <= reg2_d;
            count_q  <= count_d;
            n_q      <= n_d;
            ovf1_q   <= ovf1_d;
            ovf2_q   <= ovf2_d;
            stop_d_q <= stop_d_d;
            done_q   <= done_d;
        end
    end

    assign fib_out   = reg1_q;
    assign count_out = count_q;
    assign overflow  = ovf1_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fibonacci_datapath.sv
// -----------------------------------------------------------------------------
// tb_fibonacci_datapath
//   Directed bench for fibonacci_datapath with hand-computed expected values.
//   Inputs change 1 ns after the rising edge, and outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_fibonacci_datapath;

    localparam int WIDTH   = 16;
    localparam int N_WIDTH = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic [N_WIDTH-1:0] N_in;
    logic               En_reg1, En_reg2, En_Count, En_N, Select;
    logic               Stop;
    logic [WIDTH-1:0]   fib_out;
    logic [N_WIDTH-1:0] count_out;
    logic               overflow;
    logic               done;

    int total = 0;
    int bad   = 0;
    int ncyc;
    int npulse;

    fibonacci_datapath #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .N_in      (N_in),
        .En_reg1   (En_reg1),
        .En_reg2   (En_reg2),
        .En_Count  (En_Count),
        .En_N      (En_N),
        .Select    (Select),
        .Stop      (Stop),
        .fib_out   (fib_out),
        .count_out (count_out),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic sel, input logic en_n, input logic [N_WIDTH-1:0] n,
                         input logic e1, input logic e2, input logic ec);
        Select = sel; En_N = en_n; N_in = n;
        En_reg1 = e1; En_reg2 = e2; En_Count = ec;
    endtask

    // One init cycle with the new N, then all enables high and Select low.
    task automatic init_run(input logic [N_WIDTH-1:0] n);
        drive(1'b1, 1'b1, n, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    endtask

    // Iterate until Stop is high, with a bound. Returns the number of cycles and
    // the number of done pulses seen.
    task automatic run_to_stop(input string tag, input int bound, output int cyc);
        cyc = 0;
        while (!Stop && cyc < bound) begin
            tick();
            cyc++;
            if (done) npulse++;
        end
        if (!Stop) chk({tag, "_timeout"}, 32'(Stop), 32'd1);
    endtask

    initial begin
        // Reset with random inputs on the other pins
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 1'($urandom), N_WIDTH'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            tick();
        end
        chk("rst_fib",   fib_out,   0);
        chk("rst_count", count_out, 0);
        chk("rst_stop",  Stop,      1);
        chk("rst_ovf",   overflow,  0);
        chk("rst_done",  done,      0);

        // Reset released with idle strobes: state holds because Stop=1
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("idle_hold_fib",   fib_out,   0);
        chk("idle_hold_count", count_out, 0);

        // N=10
        init_run(8'd10);
        chk("n10_init_stop",  Stop,      0);
        chk("n10_init_count", count_out, 0);
        npulse = 0;
        run_to_stop("n10", 20, ncyc);
        chk("n10_latency", ncyc,      10);
        chk("n10_fib",     fib_out,   55);
        chk("n10_count",   count_out, 10);
        chk("n10_done_early", done,   0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) npulse++;
        end
        chk("n10_hold_fib",   fib_out,   55);
        chk("n10_hold_count", count_out, 10);
        chk("n10_hold_stop",  Stop,      1);
        chk("n10_done_once",  npulse,    1);

        // N=0: Stop right after init, nothing moves
        init_run(8'd0);
        chk("n0_stop",  Stop,      1);
        chk("n0_fib",   fib_out,   0);
        tick();
        tick();
        chk("n0_hold_fib",   fib_out,   0);
        chk("n0_hold_count", count_out, 0);

        // N=1
        init_run(8'd1);
        tick();
        chk("n1_fib",  fib_out, 1);
        chk("n1_stop", Stop,    1);

        // Overflow boundary
        init_run(8'd24);
        run_to_stop("n24", 40, ncyc);
        chk("n24_fib", fib_out,  46368);
        chk("n24_ovf", overflow, 0);

        init_run(8'd25);
        run_to_stop("n25", 40, ncyc);
        chk("n25_fib",   fib_out,  9489);
        chk("n25_ovf",   overflow, 1);
        chk("n25_count", count_out, 25);

        init_run(8'd3);
        chk("reinit_ovf_clear", overflow, 0);
        chk("reinit_fib_clear", fib_out,  0);

        // Separate enables: only reg1, then only reg2, then only reg1
        drive(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sep_r1_fib",   fib_out,   1);
        chk("sep_r1_count", count_out, 0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("sep_r2_fib", fib_out, 1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sep_r1b_fib", fib_out, 2);

        // Reset in the middle of an N=20 run
        init_run(8'd20);
        for (int i = 0; i < 7; i++) tick();
        chk("mid_count", count_out, 7);
        chk("mid_fib",   fib_out,   13);
        reset = 1'b0;
        tick();
        chk("mrst_fib",   fib_out,   0);
        chk("mrst_count", count_out, 0);
        chk("mrst_stop",  Stop,      1);
        chk("mrst_ovf",   overflow,  0);
        chk("mrst_done",  done,      0);
        reset = 1'b1;
        init_run(8'd5);
        run_to_stop("n5", 20, ncyc);
        chk("n5_fib",     fib_out, 5);
        chk("n5_latency", ncyc,    5);

        // Re-init in the middle of an N=12 run
        init_run(8'd12);
        for (int i = 0; i < 4; i++) tick();
        chk("ri_count4", count_out, 4);
        drive(1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 1'b1);
        tick();
        chk("ri_count0", count_out, 0);
        chk("ri_stop",   Stop,      0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        npulse = 0;
        run_to_stop("ri", 20, ncyc);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) npulse++;
        end
        chk("ri_fib",       fib_out,   2);
        chk("ri_count",     count_out, 3);
        chk("ri_done_once", npulse,    1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
